// File: rtl/scarv_cop_dispatch.sv
// Coprocessor issue controller: accepts one host instruction, decodes via external decoder, issues to one FU, returns one response.
// Latency: accept at cycle 0, fu_req from cycle 2, response the cycle after done (illegal: response at cycle 2).
// Backpressure: single instruction in flight; host is not acked until the previous response has been taken.
//
// Ports:
//   g_clk/g_resetn          clock, asynchronous active-low reset
//   cpu_insn_*              host instruction request/ack and encoding
//   dec_encoded, id_*       latched instruction to the decoder, decoder results back
//   fu_*                    one-hot issue request, per-unit done and result
//   cpu_rsp_*               response channel (valid/ready), status 00 ok / 01 illegal / 10 timeout
//   busy                    controller is not idle
module scarv_cop_dispatch #(
    parameter logic [7:0]  CLASS_EN  = 8'hFE,
    parameter int unsigned TIMEOUT   = 256,
    parameter int unsigned TIMEOUT_W = 9
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        cpu_insn_req,
    output logic        cpu_insn_ack,
    input  logic [31:0] cpu_insn_enc,

    output logic [31:0] dec_encoded,
    input  logic        id_exception,
    input  logic [2:0]  id_class,
    input  logic [4:0]  id_rd,

    output logic [7:0]  fu_req,
    input  logic [7:0]  fu_done,
    input  logic        fu_gpr_wen,
    input  logic [31:0] fu_gpr_wdata,

    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic [1:0]  cpu_rsp_status,
    output logic        cpu_rsp_wen,
    output logic [4:0]  cpu_rsp_rd,
    output logic [31:0] cpu_rsp_wdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Counter value seen on the last permitted EXEC cycle. Unused when the watchdog is off.
    localparam int unsigned           TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TIMEOUT_W-1:0]  CNT_LAST = TIMEOUT_W'(TO_LAST);
    localparam bit                    WDOG_ON  = (TIMEOUT != 0);

    state_t                state_q, state_d;
    logic [31:0]           dec_encoded_q, dec_encoded_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]            class_q, class_d;
    logic [4:0]            rd_q, rd_d;
    logic [7:0]            fu_req_q, fu_req_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic                  rsp_wen_q, rsp_wen_d;
    logic [31:0]           rsp_wdata_q, rsp_wdata_d;
    logic                  busy_q, busy_d;

    logic accept;
    logic dec_illegal;
    logic exec_done;
    logic exec_tmo;

    // Ack is the only combinational output; gated by reset so every output reads 0 while held in reset.
    assign accept       = (state_q == S_IDLE) && cpu_insn_req && g_resetn;
    assign cpu_insn_ack = accept;

    assign dec_illegal  = id_exception || (id_class == 3'd0) || !CLASS_EN[id_class];
    // Only the selected unit's done bit is observed; stray pulses from other units are ignored.
    assign exec_done    = fu_done[class_q];
    assign exec_tmo     = WDOG_ON && (cnt_q == CNT_LAST);

    // State register and all registered outputs.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q       <= S_IDLE;
            dec_encoded_q <= '0;
            cnt_q         <= '0;
            class_q       <= '0;
            rd_q          <= '0;
            fu_req_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= '0;
            rsp_wen_q     <= 1'b0;
            rsp_wdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dec_encoded_q <= dec_encoded_d;
            cnt_q         <= cnt_d;
            class_q       <= class_d;
            rd_q          <= rd_d;
            fu_req_q      <= fu_req_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_wen_q     <= rsp_wen_d;
            rsp_wdata_q   <= rsp_wdata_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_DECODE;
            S_DECODE: state_d = dec_illegal ? S_RESP : S_EXEC;
            S_EXEC:   if (exec_done || exec_tmo) state_d = S_RESP;
            S_RESP:   if (cpu_rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        dec_encoded_d = dec_encoded_q;
        cnt_d         = cnt_q;
        class_d       = class_q;
        rd_d          = rd_q;
        fu_req_d      = fu_req_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_wen_d     = rsp_wen_q;
        rsp_wdata_d   = rsp_wdata_q;
        busy_d        = (state_d != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (accept) dec_encoded_d = cpu_insn_enc;
            end
            S_DECODE: begin
                class_d = id_class;
                rd_d    = id_rd;
                if (dec_illegal) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_ILLEGAL;
                    rsp_wen_d    = 1'b0;
                    rsp_wdata_d  = '0;
                end else begin
                    fu_req_d = 8'd1 << id_class;
                    cnt_d    = '0;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    // Done beats a watchdog expiry in the same cycle.
                    fu_req_d     = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_wen_d    = fu_gpr_wen;
                    rsp_wdata_d  = fu_gpr_wdata;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                    if (exec_tmo) begin
                        fu_req_d     = '0;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_TIMEOUT;
                        rsp_wen_d    = 1'b0;
                        rsp_wdata_d  = '0;
                    end
                end
            end
            S_RESP: begin
                if (cpu_rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign dec_encoded    = dec_encoded_q;
    assign fu_req         = fu_req_q;
    assign cpu_rsp_valid  = rsp_valid_q;
    assign cpu_rsp_status = rsp_status_q;
    assign cpu_rsp_wen    = rsp_wen_q;
    assign cpu_rsp_rd     = rd_q;
    assign cpu_rsp_wdata  = rsp_wdata_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Bench for scarv_cop_dispatch: main instance (class mask FE) plus a second instance with mask F6.
// Expected responses come from a transaction-level model: legality, done delay vs watchdog, timing.
// Decoder is modelled in the bench from the latched instruction word.
module tb_scarv_cop_dispatch;

    localparam logic [7:0] CEN_A = 8'hFE;
    localparam logic [7:0] CEN_M = 8'hF6;
    localparam int         TMO   = 16;

    logic        g_clk;
    logic        g_resetn;
    logic        cpu_insn_req, msk_req;
    logic [31:0] cpu_insn_enc;
    logic [7:0]  fu_done;
    logic        fu_gpr_wen;
    logic [31:0] fu_gpr_wdata;
    logic        cpu_rsp_ready, msk_rsp_ready;

    logic        cpu_insn_ack, m_ack;
    logic [31:0] dec_encoded, m_dec;
    logic [7:0]  fu_req, m_fu_req;
    logic        cpu_rsp_valid, m_valid;
    logic [1:0]  cpu_rsp_status, m_status;
    logic        cpu_rsp_wen, m_wen;
    logic [4:0]  cpu_rsp_rd, m_rd;
    logic [31:0] cpu_rsp_wdata, m_wdata;
    logic        busy, m_busy;

    // Bench-side decoder: bit 31 = exception, [2:0] = class, [11:7] = rd.
    logic        id_exception, m_id_exception;
    logic [2:0]  id_class, m_id_class;
    logic [4:0]  id_rd, m_id_rd;
    assign id_exception   = dec_encoded[31];
    assign id_class       = dec_encoded[2:0];
    assign id_rd          = dec_encoded[11:7];
    assign m_id_exception = m_dec[31];
    assign m_id_class     = m_dec[2:0];
    assign m_id_rd        = m_dec[11:7];

    int n_vec = 0;
    int n_err = 0;

    scarv_cop_dispatch #(.CLASS_EN(CEN_A), .TIMEOUT(TMO), .TIMEOUT_W(9)) u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack), .cpu_insn_enc(cpu_insn_enc),
        .dec_encoded(dec_encoded), .id_exception(id_exception), .id_class(id_class), .id_rd(id_rd),
        .fu_req(fu_req), .fu_done(fu_done), .fu_gpr_wen(fu_gpr_wen), .fu_gpr_wdata(fu_gpr_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_status(cpu_rsp_status),
        .cpu_rsp_wen(cpu_rsp_wen), .cpu_rsp_rd(cpu_rsp_rd), .cpu_rsp_wdata(cpu_rsp_wdata),
        .busy(busy)
    );

    scarv_cop_dispatch #(.CLASS_EN(CEN_M), .TIMEOUT(TMO), .TIMEOUT_W(9)) u_msk (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(msk_req), .cpu_insn_ack(m_ack), .cpu_insn_enc(cpu_insn_enc),
        .dec_encoded(m_dec), .id_exception(m_id_exception), .id_class(m_id_class), .id_rd(m_id_rd),
        .fu_req(m_fu_req), .fu_done(fu_done), .fu_gpr_wen(fu_gpr_wen), .fu_gpr_wdata(fu_gpr_wdata),
        .cpu_rsp_valid(m_valid), .cpu_rsp_ready(msk_rsp_ready), .cpu_rsp_status(m_status),
        .cpu_rsp_wen(m_wen), .cpu_rsp_rd(m_rd), .cpu_rsp_wdata(m_wdata),
        .busy(m_busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] mk(input bit exc, input logic [2:0] cls, input logic [4:0] rd);
        logic [31:0] r;
        r       = $urandom;
        r[31]   = exc;
        r[2:0]  = cls;
        r[11:7] = rd;
        return r;
    endfunction

    // One full instruction on the main instance. Entered just after a rising edge with the DUT idle.
    // dly: done pulse this many cycles after fu_req rises (-1 = never). hold: cycles ready is held low.
    // pend: keep a second request (pend_enc) asserted from cycle 1 onwards.
    task automatic issue(input logic [31:0] enc, input int dly, input logic wen, input logic [31:0] wdata,
                         input int hold, input bit stray, input bit pend, input logic [31:0] pend_enc);
        logic [2:0]  cls;
        logic [4:0]  rd;
        bit          illegal;
        int          done_cyc, rsp_cyc, last;
        logic [7:0]  efu;
        logic [1:0]  est;
        logic        ewen;
        logic [31:0] ewd;
        logic [10:0] exp_ctl, got_ctl;
        logic [39:0] exp_rsp, got_rsp;

        cls     = enc[2:0];
        rd      = enc[11:7];
        illegal = enc[31] || (cls == 3'd0) || !CEN_A[cls];
        efu     = illegal ? 8'h00 : (8'd1 << cls);
        done_cyc = (dly < 0) ? -100 : 2 + dly;
        if (illegal) begin
            rsp_cyc = 2; est = 2'b01; ewen = 1'b0; ewd = 32'h0;
        end else if (dly >= 0 && dly < TMO) begin
            rsp_cyc = done_cyc + 1; est = 2'b00; ewen = wen; ewd = wdata;
        end else begin
            rsp_cyc = 2 + TMO; est = 2'b10; ewen = 1'b0; ewd = 32'h0;
        end
        last = rsp_cyc + hold;

        for (int cyc = 0; cyc <= last; cyc++) begin
            cpu_insn_req = (cyc == 0) || pend;
            cpu_insn_enc = (cyc == 0) ? enc : pend_enc;
            fu_done      = stray ? (8'($urandom) | 8'h20) : 8'h00;
            fu_done[cls] = (cyc == done_cyc);
            fu_gpr_wen   = (cyc == done_cyc) ? wen : 1'($urandom);
            fu_gpr_wdata = (cyc == done_cyc) ? wdata : $urandom;
            cpu_rsp_ready = (cyc >= rsp_cyc) ? (cyc >= rsp_cyc + hold) : 1'($urandom);
            @(negedge g_clk);
            exp_ctl = {(cyc == 0), (cyc >= 1), ((cyc >= 2 && cyc < rsp_cyc) ? efu : 8'h00), (cyc >= rsp_cyc)};
            got_ctl = {cpu_insn_ack, busy, fu_req, cpu_rsp_valid};
            n_vec++;
            if (got_ctl !== exp_ctl) begin
                n_err++;
                $display("FAIL ctl cyc=%0d enc=%h {ack,busy,fu_req,valid} got=%h exp=%h", cyc, enc, got_ctl, exp_ctl);
            end
            if (cyc >= 1) begin
                n_vec++;
                if (dec_encoded !== enc) begin
                    n_err++;
                    $display("FAIL dec_encoded cyc=%0d got=%h exp=%h", cyc, dec_encoded, enc);
                end
            end
            if (cyc >= rsp_cyc) begin
                exp_rsp = {est, ewen, rd, ewd};
                got_rsp = {cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata};
                n_vec++;
                if (got_rsp !== exp_rsp) begin
                    n_err++;
                    $display("FAIL rsp cyc=%0d enc=%h {status,wen,rd,wdata} got=%h exp=%h", cyc, enc, got_rsp, exp_rsp);
                end
            end
            @(posedge g_clk);
            #1;
        end
        cpu_insn_req  = pend;
        cpu_rsp_ready = 1'b0;
        fu_done       = 8'h00;
    endtask

    task automatic test_reset;
        cpu_insn_req = 1'b1;
        msk_req      = 1'b1;
        #12;
        n_vec++;
        if ({cpu_insn_ack, busy, fu_req, cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd,
             cpu_rsp_wdata, dec_encoded, m_ack} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs ack=%b busy=%b fu_req=%h valid=%b st=%b wen=%b rd=%h wd=%h dec=%h m_ack=%b exp all 0",
                     cpu_insn_ack, busy, fu_req, cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd,
                     cpu_rsp_wdata, dec_encoded, m_ack);
        end
        cpu_insn_req = 1'b0;
        msk_req      = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_legal;
        issue(mk(0, 3'd3, 5'd7), 5, 1'b1, 32'hDEADBEEF, 0, 0, 0, 32'h0);
        issue(mk(0, 3'd7, 5'd31), 0, 1'b0, 32'h12345678, 1, 0, 0, 32'h0);
        issue(mk(0, 3'd1, 5'd0), 2, 1'b1, 32'hFFFFFFFF, 0, 0, 0, 32'h0);
    endtask

    task automatic test_illegal;
        issue(mk(1, 3'd3, 5'd4), 3, 1'b1, 32'hA5A5A5A5, 0, 0, 0, 32'h0);
        issue(mk(0, 3'd0, 5'd9), 1, 1'b1, 32'h5A5A5A5A, 2, 0, 0, 32'h0);
    endtask

    task automatic test_mask;
        logic [31:0] enc;
        logic [11:0] exp_v, got_v;
        enc = mk(0, 3'd3, 5'd12);
        for (int cyc = 0; cyc <= 3; cyc++) begin
            msk_req       = (cyc == 0);
            cpu_insn_enc  = enc;
            msk_rsp_ready = (cyc == 2);
            fu_done       = (cyc == 2) ? 8'h08 : 8'h00;
            @(negedge g_clk);
            exp_v = {(cyc == 0), 8'h00, (cyc == 2), ((cyc == 2) ? 2'b01 : 2'b00)};
            got_v = {m_ack, m_fu_req, m_valid, (cyc == 2) ? m_status : 2'b00};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL mask_F6 cyc=%0d {ack,fu_req,valid,status} got=%h exp=%h", cyc, got_v, exp_v);
            end
            if (cyc == 2) begin
                n_vec++;
                if ({m_wen, m_rd} !== {1'b0, 5'd12}) begin
                    n_err++;
                    $display("FAIL mask_F6_fields wen=%b rd=%0d exp wen=0 rd=12", m_wen, m_rd);
                end
            end
            @(posedge g_clk);
            #1;
        end
        msk_rsp_ready = 1'b0;
        fu_done       = 8'h00;
        issue(enc, 4, 1'b1, 32'hCAFEF00D, 0, 0, 0, 32'h0);
    endtask

    task automatic test_watchdog;
        issue(mk(0, 3'd2, 5'd3), -1, 1'b1, 32'h11111111, 0, 0, 0, 32'h0);
        issue(mk(0, 3'd2, 5'd3), TMO - 1, 1'b1, 32'h22222222, 0, 0, 0, 32'h0);
        issue(mk(0, 3'd6, 5'd5), TMO, 1'b1, 32'h33333333, 1, 0, 0, 32'h0);
        issue(mk(0, 3'd4, 5'd6), TMO - 2, 1'b1, 32'h44444444, 0, 0, 0, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] e1, e2;
        e1 = mk(0, 3'd3, 5'd8);
        e2 = mk(0, 3'd5, 5'd9);
        issue(e1, 3, 1'b1, 32'h0BADF00D, 3, 1, 1, e2);
        issue(e2, 1, 1'b1, 32'h600DCAFE, 0, 0, 0, 32'h0);
    endtask

    task automatic test_reset_mid_exec;
        logic [31:0] enc;
        enc = mk(0, 3'd3, 5'd2);
        cpu_insn_req = 1'b1;
        cpu_insn_enc = enc;
        @(posedge g_clk);
        #1;
        cpu_insn_req = 1'b0;
        repeat (3) @(posedge g_clk);
        #3;
        n_vec++;
        if ({fu_req, busy} !== {8'h08, 1'b1}) begin
            n_err++;
            $display("FAIL pre_reset_exec fu_req=%h busy=%b exp fu_req=08 busy=1", fu_req, busy);
        end
        g_resetn = 1'b0;
        #1;
        n_vec++;
        if ({fu_req, busy, cpu_rsp_valid, dec_encoded} !== '0) begin
            n_err++;
            $display("FAIL async_reset fu_req=%h busy=%b valid=%b dec=%h exp all 0",
                     fu_req, busy, cpu_rsp_valid, dec_encoded);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        issue(mk(0, 3'd4, 5'd17), 2, 1'b1, 32'h76543210, 0, 0, 0, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] enc;
        int          dly, sel;
        for (int i = 0; i < 40; i++) begin
            enc = mk(($urandom_range(0, 3) == 0), 3'($urandom), 5'($urandom));
            sel = $urandom_range(0, 9);
            case (sel)
                0:       dly = -1;
                1:       dly = TMO - 1;
                2:       dly = TMO;
                3:       dly = TMO + 1;
                default: dly = $urandom_range(0, 10);
            endcase
            issue(enc, dly, 1'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom), 0, 32'h0);
        end
    endtask

    initial begin
        g_resetn      = 1'b0;
        cpu_insn_req  = 1'b0;
        msk_req       = 1'b0;
        cpu_insn_enc  = 32'h0;
        fu_done       = 8'h00;
        fu_gpr_wen    = 1'b0;
        fu_gpr_wdata  = 32'h0;
        cpu_rsp_ready = 1'b0;
        msk_rsp_ready = 1'b0;

        test_reset;
        test_legal;
        test_illegal;
        test_mask;
        test_watchdog;
        test_back_to_back;
        test_reset_mid_exec;
        test_random;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
